oled_power_sequencer: RTL

- Controller for the PMOD OLED panel.
- Runs the panel power-up sequence: VDDC on, reset pulse, init command table, VBATC on, display-on. It then owns access to the shared SPI byte engine, granting it to a host byte stream once the panel is up.
- Runs the power-down sequence: display-off, VBATC off, VDDC off.
- Sits between the UART command decoder (host side) and the SPI shifter plus panel control pins.

---
 rtl/oled_power_sequencer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/oled_power_sequencer.sv
// PMOD OLED power sequencer: rail, reset and init-table sequencing, then arbitration of
// the shared SPI byte engine between fixed display commands and a host byte stream.
module oled_power_sequencer_chk (
    input logic clk,
    input logic resetq,
    input logic vddc_n,
    input logic vbatc_n
);
    // The battery rail must never be enabled while the logic rail is off.
    rail_order_a: assert property (@(posedge clk) disable iff (!resetq) !(vddc_n && !vbatc_n));
endmodule

module oled_power_sequencer #(
    parameter int T_VDD    = 12000,
    parameter int T_RES    = 36,
    parameter int T_VBAT   = 1200000,
    parameter int T_OFF    = 1200000,
    parameter int INIT_LEN = 16
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       power_on,
    input  logic       power_off,
    input  logic [7:0] host_data,
    input  logic       host_dc,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [4:0] init_addr,
    input  logic [7:0] init_data,
    output logic [7:0] spi_data,
    output logic       spi_start,
    input  logic       spi_busy,
    output logic       oled_cs_n,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic       oled_vbatc_n,
    output logic       oled_vddc_n,
    output logic       ready
);
    typedef enum logic [3:0] {
        S_OFF, S_VDD_WAIT, S_RES_LOW, S_RES_SETTLE, S_INIT_FETCH, S_INIT_CAP,
        S_SEND_IDLE, S_SEND_START, S_SEND_GAP, S_SEND_BUSY, S_SEND_END,
        S_VBAT_WAIT, S_READY, S_OFF_WAIT
    } state_e;

    // What the SEND sub-sequence returns to once the byte has gone out.
    typedef enum logic [1:0] {K_INIT, K_ON, K_HOST, K_OFF} kind_e;

    localparam logic [23:0] LD_VDD    = 24'(T_VDD - 1);
    localparam logic [23:0] LD_RES    = 24'(T_RES - 1);
    localparam logic [23:0] LD_VBAT   = 24'(T_VBAT - 1);
    localparam logic [23:0] LD_OFF    = 24'(T_OFF - 1);
    localparam logic [4:0]  LAST_ADDR = 5'(INIT_LEN - 1);
    localparam logic [7:0]  CMD_ON    = 8'hAF;
    localparam logic [7:0]  CMD_OFF   = 8'hAE;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        tx_dc_q, tx_dc_d;
    logic [4:0]  init_addr_q, init_addr_d;
    logic        pend_off_q, pend_off_d;
    logic        vddc_n_q, vddc_n_d, vbatc_n_q, vbatc_n_d, res_n_q, res_n_d;
    logic        cs_n_q, cs_n_d, dc_q, dc_d, spi_start_q, spi_start_d;
    logic [7:0]  spi_data_q, spi_data_d;
    logic        ready_q, ready_d, host_ready_q, host_ready_d;
    logic        cnt_zero_s, host_hs_s, in_send_s;

    assign cnt_zero_s = (cnt_q == 24'd0);
    assign host_hs_s  = host_valid & host_ready_q;

    // State and output registers.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q      <= S_OFF;
            kind_q       <= K_INIT;
            cnt_q        <= 24'd0;
            byte_q       <= 8'd0;
            tx_dc_q      <= 1'b0;
            init_addr_q  <= 5'd0;
            pend_off_q   <= 1'b0;
            vddc_n_q     <= 1'b1;
            vbatc_n_q    <= 1'b1;
            res_n_q      <= 1'b1;
            cs_n_q       <= 1'b1;
            dc_q         <= 1'b0;
            spi_start_q  <= 1'b0;
            spi_data_q   <= 8'd0;
            ready_q      <= 1'b0;
            host_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            tx_dc_q      <= tx_dc_d;
            init_addr_q  <= init_addr_d;
            pend_off_q   <= pend_off_d;
            vddc_n_q     <= vddc_n_d;
            vbatc_n_q    <= vbatc_n_d;
            res_n_q      <= res_n_d;
            cs_n_q       <= cs_n_d;
            dc_q         <= dc_d;
            spi_start_q  <= spi_start_d;
            spi_data_q   <= spi_data_d;
            ready_q      <= ready_d;
            host_ready_q <= host_ready_d;
        end
    end

    // Next-state logic: sequencing, wait counters and byte selection.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        tx_dc_d     = tx_dc_q;
        init_addr_d = init_addr_q;
        case (state_q)
            S_OFF: begin
                if (power_on) begin
                    state_d     = S_VDD_WAIT;
                    cnt_d       = LD_VDD;
                    init_addr_d = 5'd0;
                end else begin
                    state_d = S_OFF;
                end
            end
            S_VDD_WAIT: begin
                if (cnt_zero_s) begin
                    state_d = S_RES_LOW;
                    cnt_d   = LD_RES;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_RES_LOW: begin
                if (cnt_zero_s) begin
                    state_d = S_RES_SETTLE;
                    cnt_d   = LD_RES;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_RES_SETTLE: begin
                if (cnt_zero_s && (INIT_LEN == 0)) begin
                    state_d = S_VBAT_WAIT;
                    cnt_d   = LD_VBAT;
                end else if (cnt_zero_s) begin
                    state_d = S_INIT_FETCH;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_INIT_FETCH: state_d = S_INIT_CAP;
            S_INIT_CAP: begin
                byte_d  = init_data;
                tx_dc_d = 1'b0;
                kind_d  = K_INIT;
                state_d = S_SEND_IDLE;
            end
            S_SEND_IDLE: begin
                if (!spi_busy) begin
                    state_d = S_SEND_START;
                end else begin
                    state_d = S_SEND_IDLE;
                end
            end
            S_SEND_START: state_d = S_SEND_GAP;
            // Busy is not trusted until the engine has had a cycle to raise it.
            S_SEND_GAP:   state_d = S_SEND_BUSY;
            S_SEND_BUSY: begin
                if (!spi_busy) begin
                    state_d = S_SEND_END;
                end else begin
                    state_d = S_SEND_BUSY;
                end
            end
            S_SEND_END: begin
                case (kind_q)
                    K_INIT: begin
                        if (init_addr_q == LAST_ADDR) begin
                            state_d = S_VBAT_WAIT;
                            cnt_d   = LD_VBAT;
                        end else begin
                            init_addr_d = init_addr_q + 5'd1;
                            state_d     = S_INIT_FETCH;
                        end
                    end
                    K_ON, K_HOST: state_d = S_READY;
                    K_OFF: begin
                        state_d = S_OFF_WAIT;
                        cnt_d   = LD_OFF;
                    end
                    default: state_d = S_OFF;
                endcase
            end
            S_VBAT_WAIT: begin
                if (cnt_zero_s) begin
                    byte_d  = CMD_ON;
                    tx_dc_d = 1'b0;
                    kind_d  = K_ON;
                    state_d = S_SEND_IDLE;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_READY: begin
                if (pend_off_q) begin
                    byte_d  = CMD_OFF;
                    tx_dc_d = 1'b0;
                    kind_d  = K_OFF;
                    state_d = S_SEND_IDLE;
                end else if (host_hs_s) begin
                    byte_d  = host_data;
                    tx_dc_d = host_dc;
                    kind_d  = K_HOST;
                    state_d = S_SEND_IDLE;
                end else begin
                    state_d = S_READY;
                end
            end
            S_OFF_WAIT: begin
                if (cnt_zero_s) begin
                    state_d = S_OFF;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: state_d = S_OFF;
        endcase
        // In OFF pend_off_q is clear, so this only latches power_off alongside power_on.
        pend_off_d = (state_d != S_OFF) & (pend_off_q | power_off);
    end

    // Output logic, decoded from the next state so every pin is registered.
    always_comb begin
        in_send_s    = (state_d == S_SEND_IDLE) || (state_d == S_SEND_START) ||
                       (state_d == S_SEND_GAP)  || (state_d == S_SEND_BUSY)  ||
                       (state_d == S_SEND_END);
        vddc_n_d     = (state_d == S_OFF);
        vbatc_n_d    = !((state_d == S_VBAT_WAIT) || (state_d == S_READY) ||
                         (in_send_s && (kind_d != K_INIT)));
        res_n_d      = (state_d != S_RES_LOW);
        cs_n_d       = !((state_d == S_SEND_START) || (state_d == S_SEND_GAP) ||
                         (state_d == S_SEND_BUSY));
        spi_start_d  = (state_d == S_SEND_START);
        ready_d      = (state_d == S_READY) || (in_send_s && (kind_d == K_HOST));
        host_ready_d = (state_d == S_READY) && !pend_off_d && !spi_busy;
        if (state_d == S_SEND_START) begin
            spi_data_d = byte_d;
            dc_d       = tx_dc_d;
        end else begin
            spi_data_d = spi_data_q;
            dc_d       = dc_q;
        end
    end

    assign host_ready   = host_ready_q;
    assign init_addr    = init_addr_q;
    assign spi_data     = spi_data_q;
    assign spi_start    = spi_start_q;
    assign oled_cs_n    = cs_n_q;
    assign oled_dc      = dc_q;
    assign oled_res_n   = res_n_q;
    assign oled_vbatc_n = vbatc_n_q;
    assign oled_vddc_n  = vddc_n_q;
    assign ready        = ready_q;

    oled_power_sequencer_chk u_chk (
        .clk     (clk),
        .resetq  (resetq),
        .vddc_n  (vddc_n_q),
        .vbatc_n (vbatc_n_q)
    );
endmodule
